// File: rtl/dbus_pkg.sv
// Shared address map, state/owner/target encodings and transaction record
// for the memory-stage data-bus arbiter and its address decoder.
package dbus_pkg;

   localparam logic [31:0] DM_BASE  = 32'h0000_0000;
   localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
   localparam logic [31:0] DEV_BASE = 32'h0000_7F00;
   localparam logic [31:0] DEV_LAST = 32'h0000_7F1F;

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
   typedef enum logic [1:0] {TGT_DM = 2'd0, TGT_DEV = 2'd1, TGT_ERR = 2'd2} target_t;

   typedef struct packed {
      owner_t      owner;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      target_t     tgt;
   } txn_t;

   // Offset compare so a window starting at zero needs no always-true test.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
      return ((addr - base) <= (last - base));
   endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bus bundle around the arbiter: two requesting masters plus the DM and device
// slave ports. The arbiter uses the slave view; the surrounding system the master view.
interface dbus_arbiter_if;

   logic        cpu_req, cpu_we, cpu_done, cpu_err, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_be;
   logic        dma_req, dma_we, dma_done, dma_err;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [3:0]  dma_be;
   logic        dm_we;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        dev_we;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output cpu_rdata, cpu_done, cpu_err, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_be,
      output dma_rdata, dma_done, dma_err,
      output dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_rdata,
      output dev_we, dev_addr, dev_wdata,
      input  dev_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_be,
      input  dma_rdata, dma_done, dma_err,
      input  dm_we, dm_addr, dm_wdata, dm_be,
      output dm_rdata,
      input  dev_we, dev_addr, dev_wdata,
      output dev_rdata
   );

endinterface

// File: rtl/dbus_addr_dec.sv
// Combinational access decoder: maps address/byte-enables to a slave target
// or flags the access as illegal. Also used by the M-stage exception logic.
module dbus_addr_dec
   import dbus_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic        we,
   output target_t     target,
   output logic        err
);

   logic in_dm_s, in_dev_s, be_ok_s;
   logic unused_we_s;

   assign in_dm_s     = in_window(addr, DM_BASE, DM_LAST);
   assign in_dev_s    = in_window(addr, DEV_BASE, DEV_LAST);
   assign unused_we_s = we;

   // Byte lanes must form a naturally aligned byte, halfword or word.
   always_comb begin
      be_ok_s = 1'b0;
      case (be)
         4'hF:                   be_ok_s = (addr[1:0] == 2'b00);
         4'h3, 4'hC:             be_ok_s = (addr[0] == 1'b0);
         4'h1, 4'h2, 4'h4, 4'h8: be_ok_s = 1'b1;
         default:                be_ok_s = 1'b0;
      endcase
   end

   // Device registers only accept full-word accesses.
   always_comb begin
      target = TGT_ERR;
      err    = 1'b1;
      if (!be_ok_s || !(in_dm_s || in_dev_s)) begin
         target = TGT_ERR;
         err    = 1'b1;
      end else if (in_dev_s) begin
         if (be == 4'hF) begin
            target = TGT_DEV;
            err    = 1'b0;
         end else begin
            target = TGT_ERR;
            err    = 1'b1;
         end
      end else begin
         target = TGT_DM;
         err    = 1'b0;
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter/sequencer: grants CPU or DMA, decodes the target and runs
// the access through IDLE -> ACC -> DONE with registered slave and response outputs.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int DEV_WAIT     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   dbus_arbiter_if.slave bus
);

   localparam int ACC_W = (DEV_WAIT > 1) ? $clog2(DEV_WAIT) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [ACC_W-1:0] DEV_LAST_CNT = ACC_W'(DEV_WAIT - 1);
   localparam logic [STV_W-1:0] STARVE_MAX   = STV_W'(STARVE_LIMIT);

   state_t           state_r, state_n;
   txn_t             txn_r, txn_n;
   logic [ACC_W-1:0] acc_cnt_r, acc_cnt_n, last_cnt_s;
   logic [STV_W-1:0] starve_r, starve_n;
   logic             grant_s, grant_dma_s;
   logic             sel_we_s;
   logic [31:0]      sel_addr_s, sel_wdata_s;
   logic [3:0]       sel_be_s;
   target_t          dec_tgt_s;
   logic             dec_err_s;
   logic [31:0]      rsp_s;
   logic             cpu_done_r, cpu_done_n, cpu_err_r, cpu_err_n;
   logic             dma_done_r, dma_done_n, dma_err_r, dma_err_n;
   logic [31:0]      cpu_rdata_r, cpu_rdata_n, dma_rdata_r, dma_rdata_n;
   logic             dm_we_r, dm_we_n, dev_we_r, dev_we_n;
   logic [31:0]      dm_addr_r, dm_addr_n, dm_wdata_r, dm_wdata_n;
   logic [31:0]      dev_addr_r, dev_addr_n, dev_wdata_r, dev_wdata_n;
   logic [3:0]       dm_be_r, dm_be_n;

   // A starved DMA overrides; otherwise the CPU has priority.
   always_comb begin
      grant_s     = 1'b0;
      grant_dma_s = 1'b0;
      if (bus.dma_req && (starve_r >= STARVE_MAX)) begin
         grant_s     = 1'b1;
         grant_dma_s = 1'b1;
      end else if (bus.cpu_req) begin
         grant_s     = 1'b1;
         grant_dma_s = 1'b0;
      end else if (bus.dma_req) begin
         grant_s     = 1'b1;
         grant_dma_s = 1'b1;
      end else begin
         grant_s     = 1'b0;
         grant_dma_s = 1'b0;
      end
   end

   // Request fields of the master that would win this cycle.
   always_comb begin
      if (grant_dma_s) begin
         sel_we_s    = bus.dma_we;
         sel_addr_s  = bus.dma_addr;
         sel_wdata_s = bus.dma_wdata;
         sel_be_s    = bus.dma_be;
      end else begin
         sel_we_s    = bus.cpu_we;
         sel_addr_s  = bus.cpu_addr;
         sel_wdata_s = bus.cpu_wdata;
         sel_be_s    = bus.cpu_be;
      end
   end

   dbus_addr_dec u_dec (
      .addr   (sel_addr_s),
      .be     (sel_be_s),
      .we     (sel_we_s),
      .target (dec_tgt_s),
      .err    (dec_err_s)
   );

   assign last_cnt_s = (txn_r.tgt == TGT_DEV) ? DEV_LAST_CNT : {ACC_W{1'b0}};

   // Next state, starvation tracking, and next values of every registered output.
   always_comb begin
      state_n     = state_r;
      txn_n       = txn_r;
      acc_cnt_n   = acc_cnt_r;
      starve_n    = starve_r;
      rsp_s       = 32'h0;
      cpu_done_n  = 1'b0;
      cpu_err_n   = 1'b0;
      cpu_rdata_n = 32'h0;
      dma_done_n  = 1'b0;
      dma_err_n   = 1'b0;
      dma_rdata_n = 32'h0;
      dm_we_n     = 1'b0;
      dm_addr_n   = 32'h0;
      dm_wdata_n  = 32'h0;
      dm_be_n     = 4'h0;
      dev_we_n    = 1'b0;
      dev_addr_n  = 32'h0;
      dev_wdata_n = 32'h0;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               txn_n.owner = grant_dma_s ? OWN_DMA : OWN_CPU;
               txn_n.we    = sel_we_s;
               txn_n.addr  = sel_addr_s;
               txn_n.wdata = sel_wdata_s;
               txn_n.be    = sel_be_s;
               txn_n.tgt   = dec_tgt_s;
               acc_cnt_n   = {ACC_W{1'b0}};
               state_n     = dec_err_s ? DONE : ACC;
            end else begin
               state_n = IDLE;
            end
            if (grant_s && grant_dma_s) begin
               starve_n = {STV_W{1'b0}};
            end else if (bus.dma_req && (starve_r < STARVE_MAX)) begin
               starve_n = starve_r + STV_W'(1);
            end else begin
               starve_n = starve_r;
            end
         end
         ACC: begin
            if (acc_cnt_r == last_cnt_s) begin
               state_n = DONE;
               if (txn_r.we) begin
                  rsp_s = 32'h0;
               end else if (txn_r.tgt == TGT_DEV) begin
                  rsp_s = bus.dev_rdata;
               end else begin
                  rsp_s = bus.dm_rdata;
               end
            end else begin
               acc_cnt_n = acc_cnt_r + ACC_W'(1);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Slave buses carry only latched fields; the write strobe fires on ACC entry.
      if (state_n == ACC) begin
         if (txn_n.tgt == TGT_DEV) begin
            dev_we_n    = txn_n.we && (state_r == IDLE);
            dev_addr_n  = txn_n.addr;
            dev_wdata_n = txn_n.wdata;
         end else begin
            dm_we_n    = txn_n.we && (state_r == IDLE);
            dm_addr_n  = txn_n.addr;
            dm_wdata_n = txn_n.wdata;
            dm_be_n    = txn_n.be;
         end
      end else if (state_n == DONE) begin
         if (txn_n.owner == OWN_DMA) begin
            dma_done_n  = 1'b1;
            dma_err_n   = (txn_n.tgt == TGT_ERR);
            dma_rdata_n = rsp_s;
         end else begin
            cpu_done_n  = 1'b1;
            cpu_err_n   = (txn_n.tgt == TGT_ERR);
            cpu_rdata_n = rsp_s;
         end
      end else begin
         dm_we_n = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         txn_r       <= '0;
         acc_cnt_r   <= {ACC_W{1'b0}};
         starve_r    <= {STV_W{1'b0}};
         cpu_done_r  <= 1'b0;
         cpu_err_r   <= 1'b0;
         cpu_rdata_r <= 32'h0;
         dma_done_r  <= 1'b0;
         dma_err_r   <= 1'b0;
         dma_rdata_r <= 32'h0;
         dm_we_r     <= 1'b0;
         dm_addr_r   <= 32'h0;
         dm_wdata_r  <= 32'h0;
         dm_be_r     <= 4'h0;
         dev_we_r    <= 1'b0;
         dev_addr_r  <= 32'h0;
         dev_wdata_r <= 32'h0;
      end else begin
         state_r     <= state_n;
         txn_r       <= txn_n;
         acc_cnt_r   <= acc_cnt_n;
         starve_r    <= starve_n;
         cpu_done_r  <= cpu_done_n;
         cpu_err_r   <= cpu_err_n;
         cpu_rdata_r <= cpu_rdata_n;
         dma_done_r  <= dma_done_n;
         dma_err_r   <= dma_err_n;
         dma_rdata_r <= dma_rdata_n;
         dm_we_r     <= dm_we_n;
         dm_addr_r   <= dm_addr_n;
         dm_wdata_r  <= dm_wdata_n;
         dm_be_r     <= dm_be_n;
         dev_we_r    <= dev_we_n;
         dev_addr_r  <= dev_addr_n;
         dev_wdata_r <= dev_wdata_n;
      end
   end

   assign bus.cpu_done  = cpu_done_r;
   assign bus.cpu_err   = cpu_err_r;
   assign bus.cpu_rdata = cpu_rdata_r;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_done_r;
   assign bus.dma_done  = dma_done_r;
   assign bus.dma_err   = dma_err_r;
   assign bus.dma_rdata = dma_rdata_r;
   assign bus.dm_we     = dm_we_r;
   assign bus.dm_addr   = dm_addr_r;
   assign bus.dm_wdata  = dm_wdata_r;
   assign bus.dm_be     = dm_be_r;
   assign bus.dev_we    = dev_we_r;
   assign bus.dev_addr  = dev_addr_r;
   assign bus.dev_wdata = dev_wdata_r;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: a transaction-schedule model checks every output each
// cycle, and directed transactions pin latencies, strobes and arbitration order.
module tb_dbus_arbiter;

   localparam int DEV_WAIT     = 2;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] dm_data_v  = 32'hDEAD_BEEF;
   logic [31:0] dev_data_v = 32'h1234_5678;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int dm_we_hits = 0, dev_we_hits = 0, done_hits = 0;

   dbus_arbiter_if bus ();

   dbus_arbiter #(.DEV_WAIT(DEV_WAIT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.dm_rdata  = dm_data_v;
   assign bus.dev_rdata = dev_data_v;

   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit legal(input logic [31:0] a, input logic [3:0] be);
      bit dm, dev, ok;
      dm  = (a <= 32'h0000_2FFF);
      dev = (a >= 32'h0000_7F00) && (a <= 32'h0000_7F1F);
      case (be)
         4'hF:                   ok = (a[1:0] == 2'b00);
         4'h3, 4'hC:             ok = !a[0] && !dev;
         4'h1, 4'h2, 4'h4, 4'h8: ok = !dev;
         default:                ok = 1'b0;
      endcase
      return ok && (dm || dev);
   endfunction

   // Model: a granted transaction is a schedule of offsets from its grant cycle.
   bit          m_busy = 1'b0, m_dma, m_we, m_err, m_dev;
   int          m_t0 = 0, m_len = 1, m_starve = 0, m_d, m_done_at;
   logic [31:0] m_addr, m_wdata, m_cap;
   logic [3:0]  m_be;
   logic        e_cdone, e_cerr, e_ddone, e_derr, e_dm_we, e_dev_we, e_stall;
   logic [31:0] e_crd, e_drd, e_dm_addr, e_dm_wdata, e_dev_addr, e_dev_wdata;
   logic [3:0]  e_dm_be;

   always @(negedge clk) begin
      {e_cdone, e_cerr, e_ddone, e_derr, e_dm_we, e_dev_we} = 6'b0;
      {e_crd, e_drd, e_dm_addr, e_dm_wdata, e_dev_addr, e_dev_wdata} = '0;
      e_dm_be   = 4'h0;
      m_d       = cyc - m_t0;
      m_done_at = m_err ? 1 : m_len + 1;
      if (m_busy) begin
         if (!m_err && m_d >= 1 && m_d <= m_len) begin
            if (m_dev) begin
               e_dev_we = m_we && (m_d == 1);
               e_dev_addr = m_addr;
               e_dev_wdata = m_wdata;
            end else begin
               e_dm_we = m_we && (m_d == 1);
               e_dm_addr = m_addr;
               e_dm_wdata = m_wdata;
               e_dm_be = m_be;
            end
         end
         if (!m_err && !m_we && m_d == m_len) m_cap = m_dev ? dev_data_v : dm_data_v;
         if (m_d == m_done_at) begin
            if (m_dma) begin
               e_ddone = 1'b1; e_derr = m_err; e_drd = (m_err || m_we) ? 32'h0 : m_cap;
            end else begin
               e_cdone = 1'b1; e_cerr = m_err; e_crd = (m_err || m_we) ? 32'h0 : m_cap;
            end
         end
      end
      e_stall = bus.cpu_req & ~e_cdone;
      chk1("cpu_done", bus.cpu_done, e_cdone);
      chk1("cpu_err", bus.cpu_err, e_cerr);
      chk32("cpu_rdata", bus.cpu_rdata, e_crd);
      chk1("cpu_stall", bus.cpu_stall, e_stall);
      chk1("dma_done", bus.dma_done, e_ddone);
      chk1("dma_err", bus.dma_err, e_derr);
      chk32("dma_rdata", bus.dma_rdata, e_drd);
      chk1("dm_we", bus.dm_we, e_dm_we);
      chk32("dm_addr", bus.dm_addr, e_dm_addr);
      chk32("dm_wdata", bus.dm_wdata, e_dm_wdata);
      chk32("dm_be", {28'h0, bus.dm_be}, {28'h0, e_dm_be});
      chk1("dev_we", bus.dev_we, e_dev_we);
      chk32("dev_addr", bus.dev_addr, e_dev_addr);
      chk32("dev_wdata", bus.dev_wdata, e_dev_wdata);
      if (reset) begin
         m_busy = 1'b0;
         m_starve = 0;
      end else if (m_busy) begin
         if (m_d == m_done_at) m_busy = 1'b0;
      end else if (bus.cpu_req || bus.dma_req) begin
         m_dma = bus.dma_req && (m_starve >= STARVE_LIMIT || !bus.cpu_req);
         if (m_dma) m_starve = 0;
         else if (bus.dma_req && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
         m_busy  = 1'b1;
         m_t0    = cyc;
         m_we    = m_dma ? bus.dma_we : bus.cpu_we;
         m_addr  = m_dma ? bus.dma_addr : bus.cpu_addr;
         m_wdata = m_dma ? bus.dma_wdata : bus.cpu_wdata;
         m_be    = m_dma ? bus.dma_be : bus.cpu_be;
         m_err   = !legal(m_addr, m_be);
         m_dev   = (m_addr >= 32'h0000_7F00);
         m_len   = m_dev ? DEV_WAIT : 1;
      end
      if (bus.dm_we) dm_we_hits++;
      if (bus.dev_we) dev_we_hits++;
      if (bus.cpu_done || bus.dma_done) done_hits++;
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction from the current IDLE cycle T; latency counted in cycles after T.
   task automatic txn(input string name, input bit is_dma, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd, input int exp_dm_we,
                      input int exp_dev_we, input logic [31:0] exp_addr1);
      int lat = -1;
      bit stall_ok = 1'b1;
      logic err = 1'b0;
      logic [31:0] rd = 32'h0, addr1 = 32'h0;
      dm_we_hits = 0;
      dev_we_hits = 0;
      if (is_dma) begin
         bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_be = be; bus.dma_wdata = wdata;
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_be = be; bus.cpu_wdata = wdata;
      end
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(negedge clk);
         if (k == 1) addr1 = bus.dm_addr | bus.dev_addr;
         if (is_dma ? bus.dma_done : bus.cpu_done) begin
            lat = k;
            err = is_dma ? bus.dma_err : bus.cpu_err;
            rd  = is_dma ? bus.dma_rdata : bus.cpu_rdata;
         end else if (!is_dma && !bus.cpu_stall) begin
            stall_ok = 1'b0;
         end
      end
      tick();
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      chk32({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk1({name, "_err"}, err, exp_err);
      chk32({name, "_rdata"}, rd, exp_rd);
      chk32({name, "_dm_we_cycles"}, 32'(dm_we_hits), 32'(exp_dm_we));
      chk32({name, "_dev_we_cycles"}, 32'(dev_we_hits), 32'(exp_dev_we));
      chk32({name, "_slave_addr"}, addr1, exp_addr1);
      if (!is_dma) chk1({name, "_stall"}, stall_ok, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, k1, k2, last_k;
      logic [5:0] seq;
      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0; bus.cpu_be = 4'h0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0; bus.dma_be = 4'h0;
      repeat (3) tick();
      @(negedge clk);
      chk1("reset_cpu_done", bus.cpu_done, 1'b0);
      chk1("reset_dm_we", bus.dm_we, 1'b0);
      chk32("reset_dev_addr", bus.dev_addr, 32'h0);
      tick();
      reset = 1'b0;

      //   name            dma we  addr          be    wdata         lat err rdata         dmwe devwe addr@T+1
      txn("dm_read",      0, 0, 32'h0000_0010, 4'hF, 32'h0,        2, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0010);
      txn("dev_write",    0, 1, 32'h0000_7F04, 4'hF, 32'h55,       3, 0, 32'h0,         0, 1, 32'h0000_7F04);
      txn("dev_half_err", 0, 1, 32'h0000_7F00, 4'h3, 32'h77,       1, 1, 32'h0,         0, 0, 32'h0);
      txn("oob_read_err", 0, 0, 32'h0000_3000, 4'hF, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0);
      txn("misalign_err", 0, 0, 32'h0000_0002, 4'hF, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0);
      txn("dm_half_wr",   0, 1, 32'h0000_0102, 4'hC, 32'hABCD_0000, 2, 0, 32'h0,        1, 0, 32'h0000_0102);
      txn("dm_last_word", 0, 0, 32'h0000_2FFC, 4'hF, 32'h0,        2, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_2FFC);
      txn("dev_read",     0, 0, 32'h0000_7F1C, 4'hF, 32'h0,        3, 0, 32'h1234_5678, 0, 0, 32'h0000_7F1C);
      txn("dev_past_end", 0, 0, 32'h0000_7F20, 4'hF, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0);
      txn("bad_be_5",     0, 0, 32'h0000_0000, 4'h5, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0);
      txn("byte_odd",     0, 1, 32'h0000_0003, 4'h8, 32'h1100_0000, 2, 0, 32'h0,        1, 0, 32'h0000_0003);
      txn("dma_dev_wr",   1, 1, 32'h0000_7F10, 4'hF, 32'hCAFE,     3, 0, 32'h0,         0, 1, 32'h0000_7F10);
      txn("dma_be0_err",  1, 0, 32'h0000_0010, 4'h0, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0);

      // Both masters held: four CPU grants, then the starved DMA, then CPU again.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20; bus.cpu_be = 4'hF;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40; bus.dma_be = 4'hF;
      n = 0; seq = 6'b0; last_k = -1;
      for (int k = 0; k < 60 && n < 6; k++) begin
         @(negedge clk);
         if (bus.cpu_done || bus.dma_done) begin
            seq = {seq[4:0], bus.dma_done};
            n++;
            last_k = k;
         end
      end
      tick();
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      chk32("starve_order", {26'h0, seq}, 32'h0000_0002);
      chk32("starve_last_done", 32'(last_k), 32'd17);

      // Reset in the second ACC cycle of a device read.
      done_hits = 0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h7F08; bus.cpu_be = 4'hF;
      tick();
      tick();
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk1("rst_acc_cpu_done", bus.cpu_done, 1'b0);
      chk32("rst_acc_dev_addr", bus.dev_addr, 32'h0);
      chk32("rst_acc_cpu_rdata", bus.cpu_rdata, 32'h0);
      tick();
      tick();
      chk32("rst_acc_done_pulses", 32'(done_hits), 32'd0);
      txn("post_reset_rd", 0, 0, 32'h0000_0030, 4'hF, 32'h0, 2, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0030);

      // Request held through done: a second read starts in the IDLE after DONE.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44; bus.cpu_be = 4'hF;
      n = 0; k1 = -1; k2 = -1;
      for (int k = 0; k < 30 && n < 2; k++) begin
         @(negedge clk);
         if (bus.cpu_done) begin
            if (n == 0) k1 = k;
            else k2 = k;
            n++;
         end
      end
      tick();
      bus.cpu_req = 1'b0;
      chk32("b2b_first_done", 32'(k1), 32'd2);
      chk32("b2b_second_done", 32'(k2), 32'd5);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
